// File: rtl/reg_fifo_pkg.sv
// reg_fifo_pkg
//   Shared types and helpers for the register-based FIFO.
//   fifo_op_e : the accepted operation in a cycle, encoded as {push_ok, pop_ok}
//   ptr_width : pointer width for a given depth, never less than 1 bit
package reg_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_fifo_reg_n.sv
// reg_n
//   Parametrised enabled register with asynchronous active-low clear.
//   This is the general replacement for the old fixed-width registers.
// Ports
//   clk : rising-edge clock
//   clr : asynchronous active-low clear, forces q to 0
//   en  : load enable
//   d   : WIDTH-bit data in
//   q   : WIDTH-bit registered data out
module reg_n #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_fifo.sv
// reg_fifo
//   Register-based first-word-fall-through FIFO. Each stored word is a reg_n;
//   data never moves, only the read/write pointers do.
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset (pointers, count, flags, storage)
//   clear       : synchronous flush, overrides wr_en/rd_en, clears sticky flags
//   wr_en       : push request
//   wr_data     : word to push
//   rd_en       : pop request
//   rd_data     : head word, 0 when empty
//   full        : count == DEPTH
//   empty       : count == 0
//   almost_full : count >= AFULL_LVL
//   count       : occupancy
//   overflow    : sticky, a push was rejected
//   underflow   : sticky, a pop was rejected
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH     = 17,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic             push_ok, pop_ok;
  fifo_op_e         op;

  // Flags come only from registered count.
  assign full        = (count_reg == CW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= CW'(AFULL_LVL));
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // A push into a full FIFO is allowed when a pop frees the head slot in the
  // same cycle; wr_ptr then equals rd_ptr, so the new word lands in that slot.
  assign push_ok = wr_en & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic load;
      assign load = push_ok & ~clear & (wr_ptr_reg == PW'(gi));
      reg_n #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .clr (reset),
        .en  (load),
        .d   (wr_data),
        .q   (word_q[gi])
      );
    end
  endgenerate

  // Head mux written as a compare loop so a non-power-of-2 DEPTH never
  // indexes past the storage array.
  always_comb begin
    rd_data = '0;
    if (!empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_ptr_reg == PW'(i)) begin
          rd_data = word_q[i];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clear) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      case (op)
        OP_PUSH: count_next = count_reg + CW'(1);
        OP_POP:  count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      if (wr_en && !push_ok) overflow_next  = 1'b1;
      if (rd_en && !pop_ok)  underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo
//   Directed bench for reg_fifo. Instance a is DEPTH=4/WIDTH=17/AFULL_LVL=3,
//   instance b is DEPTH=3 for pointer-wrap coverage. Expected pop data goes
//   into a per-instance queue; a monitor on each instance compares every
//   accepted pop against the queue head.
module tb_reg_fifo;

  localparam int WIDTH = 17;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // instance a
  logic             clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic             full, empty, almost_full, overflow, underflow;
  logic [2:0]       count;

  // instance b
  logic             b_clear = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0;
  logic [WIDTH-1:0] b_wr_data = '0;
  logic [WIDTH-1:0] b_rd_data;
  logic             b_full, b_empty, b_almost_full, b_overflow, b_underflow;
  logic [1:0]       b_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_a[$];
  logic [WIDTH-1:0] exp_b[$];

  always #5 clk = ~clk;

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(4), .AFULL_LVL(3)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(3), .AFULL_LVL(2)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .full(b_full), .empty(b_empty),
    .almost_full(b_almost_full), .count(b_count), .overflow(b_overflow),
    .underflow(b_underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an accepted pop is rd_en with a non-empty FIFO out of reset/clear.
  always @(negedge clk) begin
    if (reset && !clear && rd_en && !empty) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL pop_a: got %0h, required no pop", rd_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_a.pop_front();
        $display("[%0t] a pop data=%05h", $time, rd_data);
        if (rd_data !== e) begin
          errors++;
          $display("FAIL pop_a: got %05h, required %05h", rd_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && !b_clear && b_rd_en && !b_empty) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL pop_b: got %0h, required no pop", b_rd_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_b.pop_front();
        $display("[%0t] b pop data=%05h", $time, b_rd_data);
        if (b_rd_data !== e) begin
          errors++;
          $display("FAIL pop_b: got %05h, required %05h", b_rd_data, e);
        end
      end
    end
  end

  task automatic push_a(input logic [WIDTH-1:0] d, input bit accepted);
    $display("[%0t] a push data=%05h", $time, d);
    if (accepted) exp_a.push_back(d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_a();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic both_a(input logic [WIDTH-1:0] d);
    $display("[%0t] a push+pop data=%05h", $time, d);
    exp_a.push_back(d);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic clear_a();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_flags", {overflow, underflow}, 0);
    reset = 1'b1;
    tick();

    // 1. Reset mid-stream
    push_a(17'h00AAA, 1);
    push_a(17'h00BBB, 1);
    check("t1_count2", count, 2);
    #1 reset = 1'b0;
    #1;
    check("t1_async_empty", empty, 1);
    check("t1_async_count", count, 0);
    check("t1_async_rd_data", rd_data, 0);
    exp_a.delete();
    reset = 1'b1;
    tick();
    push_a(17'h12345, 1);
    check("t1_readback", rd_data, 17'h12345);
    check("t1_count1", count, 1);
    pop_a();
    check("t1_drained", empty, 1);

    // 2. Fill / drain
    push_a(17'h1ABCD, 1);
    check("t2_af1", almost_full, 0);
    push_a(17'h00001, 1);
    check("t2_af2", almost_full, 0);
    push_a(17'h10000, 1);
    check("t2_af3", almost_full, 1);
    check("t2_full3", full, 0);
    push_a(17'h0FFFF, 1);
    check("t2_full4", full, 1);
    check("t2_count4", count, 4);

    // 3. Overflow while full
    push_a(17'h1FFFF, 0);
    check("t3_count", count, 4);
    check("t3_overflow", overflow, 1);
    check("t3_head", rd_data, 17'h1ABCD);
    tick();
    check("t3_sticky", overflow, 1);

    for (int i = 0; i < 4; i++) begin
      pop_a();
    end
    check("t2_empty", empty, 1);
    check("t2_count0", count, 0);
    check("t3_still_set", overflow, 1);
    clear_a();
    check("t3_cleared", overflow, 0);

    // 4. Full with simultaneous push+pop
    push_a(17'h00011, 1);
    push_a(17'h00022, 1);
    push_a(17'h00033, 1);
    push_a(17'h00044, 1);
    both_a(17'h00055);
    check("t4_count", count, 4);
    check("t4_no_ovf", overflow, 0);
    check("t4_head", rd_data, 17'h00022);
    for (int i = 0; i < 4; i++) begin
      pop_a();
    end
    check("t4_empty", empty, 1);

    // 5. Empty with simultaneous push+pop
    both_a(17'h00007);
    check("t5_underflow", underflow, 1);
    check("t5_count", count, 1);
    check("t5_rd_data", rd_data, 17'h00007);
    pop_a();
    check("t5_sticky", underflow, 1);
    clear_a();
    check("t5_cleared", underflow, 0);
    check("t5_clear_empty", empty, 1);

    // 6. Wrap on DEPTH=3: fill, then 10 push+pop pairs, then drain
    for (int i = 1; i <= 3; i++) begin
      exp_b.push_back(WIDTH'(i));
      b_wr_en = 1'b1; b_wr_data = WIDTH'(i);
      tick();
    end
    b_wr_en = 1'b0;
    check("t6_full", b_full, 1);
    for (int i = 4; i <= 13; i++) begin
      $display("[%0t] b push+pop data=%05h", $time, WIDTH'(i));
      exp_b.push_back(WIDTH'(i));
      b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_data = WIDTH'(i);
      tick();
      check("t6_count", b_count, 3);
    end
    b_wr_en = 1'b0;
    b_rd_en = 1'b1;
    tick(); tick(); tick();
    b_rd_en = 1'b0;
    check("t6_empty", b_empty, 1);
    check("t6_flags", {b_overflow, b_underflow}, 0);

    check("sb_a_drained", exp_a.size(), 0);
    check("sb_b_drained", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the clock or stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
